// File: rtl/cipher_stream_ctrl.sv
// Streaming shift-cipher controller: loads a repeating key, then encrypts
// or decrypts a message byte-by-byte through a one-deep output register.
module cipher_stream_ctrl #(
    parameter int SEC_LEN = 3,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             key_valid,
    input  logic [7:0]       key_byte,
    output logic             key_ready,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [KW-1:0] KLAST = KW'(SEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       key_mem_q [SEC_LEN];
    logic [7:0]       key_mem_d [SEC_LEN];
    logic [KW-1:0]    kcnt_q, kcnt_d;
    logic [KW-1:0]    kidx_q, kidx_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             ov_q, ov_d;
    logic [7:0]       od_q, od_d;
    logic             err_q, err_d;

    logic start_ok;
    logic start_bad;
    logic key_hs;
    logic in_hs;
    logic out_hs;
    logic last_in;

    assign start_ok  = (state_q == IDLE) && start && (msg_len != '0);
    assign start_bad = (state_q == IDLE) && start && (msg_len == '0);
    assign key_hs    = key_valid && key_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = ov_q && out_ready;
    assign last_in   = (bcnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_ok) state_d = LOAD_KEY;
            LOAD_KEY: if (key_hs && kcnt_q == KLAST) state_d = RUN;
            RUN:      if (in_hs && last_in) state_d = DRAIN;
            DRAIN:    if (out_hs) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state_q == LOAD_KEY);
        in_ready  = (state_q == RUN) && (!ov_q || out_ready);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    // Datapath: key memory, counters and the one-deep output register
    always_comb begin
        key_mem_d = key_mem_q;
        kcnt_d    = kcnt_q;
        kidx_d    = kidx_q;
        bcnt_d    = bcnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        ov_d      = ov_q;
        od_d      = od_q;
        err_d     = start_bad;
        if (start_ok) begin
            mode_d = mode;
            len_d  = msg_len;
            kcnt_d = '0;
            kidx_d = '0;
            bcnt_d = '0;
        end
        if (key_hs) begin
            key_mem_d[kcnt_q] = key_byte;
            kcnt_d = (kcnt_q == KLAST) ? '0 : kcnt_q + 1'b1;
        end
        if (out_hs) begin
            ov_d = 1'b0;
        end
        if (in_hs) begin
            ov_d   = 1'b1;
            od_d   = mode_q ? in_data - key_mem_q[kidx_q]
                            : in_data + key_mem_q[kidx_q];
            kidx_d = (kidx_q == KLAST) ? '0 : kidx_q + 1'b1;
            bcnt_d = bcnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SEC_LEN; i++) begin
                key_mem_q[i] <= '0;
            end
            kcnt_q <= '0;
            kidx_q <= '0;
            bcnt_q <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            key_mem_q <= key_mem_d;
            kcnt_q    <= kcnt_d;
            kidx_q    <= kidx_d;
            bcnt_q    <= bcnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            err_q     <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl: directed scenarios plus randomized handshakes
// checked against a modular-arithmetic reference model.
module tb_cipher_stream_ctrl;

    localparam int LW = 16;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          start, mode, key_valid, key_ready;
    logic [1:0]          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]          busy, done, err;
    logic [1:0][LW-1:0]  msg_len;
    logic [1:0][7:0]     key_byte, in_data, out_data;

    int checks = 0;
    int errors = 0;

    cipher_stream_ctrl #(.SEC_LEN(3), .LEN_W(LW)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
        .msg_len(msg_len[0]), .key_valid(key_valid[0]),
        .key_byte(key_byte[0]), .key_ready(key_ready[0]),
        .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    cipher_stream_ctrl #(.SEC_LEN(1), .LEN_W(LW)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
        .msg_len(msg_len[1]), .key_valid(key_valid[1]),
        .key_byte(key_byte[1]), .key_ready(key_ready[1]),
        .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: byte i is shifted by key byte (i mod keylen), mod 256
    function automatic bq_t model(input bit md, input bq_t key, input bq_t msg);
        bq_t r;
        int s;
        for (int i = 0; i < msg.size(); i++) begin
            s = md ? int'(msg[i]) - int'(key[i % key.size()])
                   : int'(msg[i]) + int'(key[i % key.size()]);
            r.push_back(8'(((s % 256) + 256) % 256));
        end
        return r;
    endfunction

    task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic idle_all();
        start = '0; mode = '0; msg_len = '0; key_valid = '0;
        key_byte = '0; in_valid = '0; in_data = '0; out_ready = '0;
    endtask

    task automatic run_msg(input int d, input bit md, input bq_t key,
                           input bq_t msg, input int stall_at,
                           output bq_t got);
        int kp = 0, mp = 0, cyc = 0, ndone = 0, last_oh = -100, scnt = 0;
        bit stall_prev = 0;
        logic [7:0] prev_data = '0;
        got = {};
        @(posedge clk); #1;
        start[d] = 1'b1; mode[d] = md; msg_len[d] = LW'(msg.size());
        @(posedge clk); #1;
        start[d] = 1'b0;
        while (ndone == 0 && cyc < 400) begin
            key_valid[d] = (kp < key.size()) && ($urandom % 4 != 0);
            key_byte[d]  = (kp < key.size()) ? key[kp] : 8'($urandom);
            in_valid[d]  = (mp < msg.size()) && ($urandom % 4 != 0);
            in_data[d]   = (mp < msg.size()) ? msg[mp] : 8'($urandom);
            out_ready[d] = ($urandom % 4 != 0);
            if (stall_at >= 0 && got.size() >= stall_at && scnt < 5
                && out_valid[d]) begin
                out_ready[d] = 1'b0;
                in_valid[d]  = (mp < msg.size());
                scnt++;
            end
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                chk("hold_valid", out_valid[d], 1);
                chk("hold_data", out_data[d], prev_data);
            end
            if (out_valid[d] && !out_ready[d])
                chk("bp_in_ready", in_ready[d], 0);
            stall_prev = out_valid[d] && !out_ready[d];
            prev_data  = out_data[d];
            if (key_valid[d] && key_ready[d]) kp++;
            if (in_valid[d] && in_ready[d]) mp++;
            if (done[d]) begin
                ndone++;
                chk("done_after_hs", cyc, last_oh + 1);
            end
            if (out_valid[d] && out_ready[d]) begin
                got.push_back(out_data[d]);
                last_oh = cyc;
            end
            @(posedge clk); #1;
        end
        chk("done_seen", ndone, 1);
        chk("key_consumed", kp, key.size());
        key_valid[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done[d], 0);
        chk("busy_after", busy[d], 0);
    endtask

    initial begin
        bq_t kkey, k20, hello, enc, got, rk, rm;
        kkey  = '{8'h4B, 8'h45, 8'h59};
        k20   = '{8'h20};
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        idle_all();
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_out_data", out_data[d], 0);
            chk("rst_key_ready", key_ready[d], 0);
            chk("rst_done_err", {done[d], err[d], in_ready[d]}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Encrypt HELLO under KEY
        run_msg(0, 1'b0, kkey, hello, -1, enc);
        cmp_q("enc_model", enc, model(1'b0, kkey, hello));
        cmp_q("enc_lit", enc, '{8'h93, 8'h8A, 8'hA5, 8'h97, 8'h94});

        run_msg(0, 1'b1, kkey, '{8'h93}, -1, got);
        cmp_q("dec_one", got, '{8'h48});
        run_msg(0, 1'b1, kkey, enc, -1, got);
        cmp_q("dec_roundtrip", got, hello);

        // Wrap arithmetic on the single-byte key instance
        run_msg(1, 1'b0, k20, '{8'hF0}, -1, got);
        cmp_q("wrap_enc", got, '{8'h10});
        run_msg(1, 1'b1, k20, '{8'h10}, -1, got);
        cmp_q("wrap_dec", got, '{8'hF0});
        run_msg(1, 1'b1, k20, '{8'h05}, -1, got);
        cmp_q("wrap_dec2", got, '{8'hE5});

        // Forced five-cycle backpressure mid-message
        rm = {};
        for (int i = 0; i < 10; i++) rm.push_back(8'($urandom));
        run_msg(0, 1'b0, kkey, rm, 3, got);
        cmp_q("bp_stream", got, model(1'b0, kkey, rm));

        // Zero-length start
        @(posedge clk); #1;
        start[0] = 1'b1; msg_len[0] = '0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(negedge clk);
        chk("zl_err", err[0], 1);
        chk("zl_busy", busy[0], 0);
        chk("zl_ready", {key_ready[0], in_ready[0]}, 0);
        @(negedge clk);
        chk("zl_err_pulse", err[0], 0);
        chk("zl_idle", {busy[0], key_ready[0]}, 0);

        // Reset in the middle of RUN
        @(posedge clk); #1;
        start[0] = 1'b1; mode[0] = 1'b0; msg_len[0] = 5;
        @(posedge clk); #1;
        start[0] = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_valid[0] = 1'b1; key_byte[0] = kkey[i];
            @(posedge clk); #1;
        end
        key_valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[0] = 1'b1; in_data[0] = hello[i];
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", out_valid[0], 0);
        chk("mr_out_data", out_data[0], 0);
        chk("mr_busy", busy[0], 0);
        chk("mr_flags", {done[0], err[0], key_ready[0], in_ready[0]}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_done", done[0], 0);
        end
        run_msg(0, 1'b0, kkey, hello, -1, got);
        cmp_q("mr_restart", got, '{8'h93, 8'h8A, 8'hA5, 8'h97, 8'h94});

        // Randomized messages on both instances
        for (int t = 0; t < 8; t++) begin
            int d;
            bit md;
            d  = t % 2;
            md = 1'($urandom);
            rk = {};
            rm = {};
            for (int i = 0; i < (d ? 1 : 3); i++) rk.push_back(8'($urandom));
            for (int i = 0; i < 1 + int'($urandom % 12); i++)
                rm.push_back(8'($urandom));
            run_msg(d, md, rk, rm, (t == 2) ? 1 : -1, got);
            cmp_q($sformatf("rand%0d", t), got, model(md, rk, rm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
